dm_lsu: RTL and testbench

Load/store unit that initiates all accesses to the word-organised data memory. It accepts byte, halfword and word load/store requests from the pipeline over a valid/ready handshake. It translates byte addresses into word addresses and performs read-modify-write for sub-word stores. Loads are returned aligned and sign- or zero-extended. It sits between the pipeline MEM stage and the data memory, and drives that memory's addr/rd/wr/wdata while consuming its combinational rdata.

---
 rtl/dm_lsu_if.sv | 53 +++++
 rtl/dm_lsu.sv | 234 +++++++++++++++++++++++
 tb/tb_dm_lsu.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_lsu_if.sv
// -----------------------------------------------------------------------------
// dm_lsu_if
// Bundles the signals around the load/store unit:
//   - pipeline request channel  (req_valid/req_ready + request fields)
//   - pipeline response channel (resp_valid/resp_ready + result fields)
//   - data memory port          (dm_addr/dm_rd/dm_wr/dm_wdata/dm_rdata)
// Modports:
//   slave  : the load/store unit itself (consumes requests, drives memory)
//   master : the environment around it (pipeline stage + data memory)
// -----------------------------------------------------------------------------
interface dm_lsu_if #(
    parameter int AW = 5
);
    // request channel
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_sign;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;

    // response channel
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    // data memory port
    logic [AW-1:0] dm_addr;
    logic          dm_rd;
    logic          dm_wr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        input  resp_ready,
        input  dm_rdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output dm_addr, dm_rd, dm_wr, dm_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        output resp_ready,
        output dm_rdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  dm_addr, dm_rd, dm_wr, dm_wdata
    );
endinterface

// File: rtl/dm_lsu.sv
// -----------------------------------------------------------------------------
// dm_lsu
// Load/store unit in front of a word-organised data memory. Accepts byte,
// halfword and word loads/stores, converts byte addresses to word addresses,
// performs read-modify-write for sub-word stores and returns loads aligned
// and sign/zero-extended.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dm_lsu_if.slave
//            req_*  - request channel from the pipeline (valid/ready)
//            resp_* - response channel back to the pipeline (valid/ready)
//            dm_*   - data memory port (dm_rdata is combinational from dm_addr)
//
// All bus outputs are Moore outputs decoded from the registered state, so an
// asserted reset forces them to their idle values immediately.
// -----------------------------------------------------------------------------
module dm_lsu #(
    parameter int AW = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_lsu_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_ERR,
        S_RESP
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    // Latched request
    logic [AW-1:0]  waddr_reg;
    logic [1:0]     off_reg;
    logic [1:0]     size_reg;
    logic           sign_reg;
    // Store data; overwritten with the merged word during RMW_RD so that
    // WRITE always drives this register regardless of store size.
    logic [31:0]    data_reg;

    // Response registers
    logic [31:0]    rdata_reg;
    logic           err_reg;

    // Combinational decodes
    logic           req_bad;
    logic [31:0]    lane_shifted;
    logic [31:0]    load_ext;
    logic [31:0]    merged;

    logic           ready_c;
    logic           rd_c;
    logic           wr_c;
    logic           resp_valid_c;

    // Upper request address bits are dropped on purpose (address wrap).
    logic           unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:AW+2];

    // Misaligned or illegal-size request
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            2'd0:    req_bad = 1'b0;
            2'd1:    req_bad = bus.req_addr[0];
            2'd2:    req_bad = (bus.req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        ready_c      = 1'b0;
        rd_c         = 1'b0;
        wr_c         = 1'b0;
        resp_valid_c = 1'b0;
        case (state_reg)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (req_bad) begin
                        state_next = S_ERR;
                    end else if (!bus.req_we) begin
                        state_next = S_LOAD;
                    end else if (bus.req_size == 2'd2) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                rd_c       = 1'b1;
                state_next = S_RESP;
            end
            S_RMW_RD: begin
                rd_c       = 1'b1;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                wr_c       = 1'b1;
                state_next = S_RESP;
            end
            S_ERR: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load path: bring the addressed lane down to bit 0, then extend
    // -------------------------------------------------------------------------
    assign lane_shifted = bus.dm_rdata >> {off_reg, 3'b000};

    always_comb begin
        load_ext = lane_shifted;
        case (size_reg)
            2'd0:    load_ext = {{24{sign_reg & lane_shifted[7]}},  lane_shifted[7:0]};
            2'd1:    load_ext = {{16{sign_reg & lane_shifted[15]}}, lane_shifted[15:0]};
            default: load_ext = lane_shifted;
        endcase
    end

    // -------------------------------------------------------------------------
    // Store merge: each byte lane either takes the new store data or keeps
    // the byte read from memory. A half store covers the lane pair selected
    // by offset bit 1; its low byte goes to the even lane.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;

            assign hit = (size_reg == 2'd0) ? (off_reg == LANE)
                                            : (off_reg[1] == LANE[1]);
            assign src = (size_reg != 2'd0 && LANE[0]) ? data_reg[15:8]
                                                       : data_reg[7:0];
            assign merged[8*gi +: 8] = hit ? src : bus.dm_rdata[8*gi +: 8];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_reg <= '0;
            off_reg   <= 2'b00;
            size_reg  <= 2'b00;
            sign_reg  <= 1'b0;
            data_reg  <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        waddr_reg <= bus.req_addr[AW+1:2];
                        off_reg   <= bus.req_addr[1:0];
                        size_reg  <= bus.req_size;
                        sign_reg  <= bus.req_sign;
                        data_reg  <= bus.req_wdata;
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    rdata_reg <= load_ext;
                end
                S_RMW_RD: begin
                    data_reg <= merged;
                end
                S_ERR: begin
                    rdata_reg <= 32'd0;
                    err_reg   <= 1'b1;
                end
                S_RESP: begin
                    // Response is held until consumed, then cleared.
                    if (bus.resp_ready) begin
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = err_reg;
    assign bus.dm_addr    = (state_reg != S_IDLE) ? waddr_reg : '0;
    assign bus.dm_rd      = rd_c;
    assign bus.dm_wr      = wr_c;
    assign bus.dm_wdata   = wr_c ? data_reg : 32'd0;

endmodule

// File: tb/tb_dm_lsu.sv
// -----------------------------------------------------------------------------
// tb_dm_lsu
// Bench for dm_lsu: a memory behind the DUT, a transaction-level reference
// model (reference memory image + expected response per accepted request),
// a per-cycle compare process, directed cases with literal expectations and
// a randomized phase.
// -----------------------------------------------------------------------------
module tb_dm_lsu;
    localparam int AW    = 5;
    localparam int WORDS = 1 << AW;

    logic clk;
    logic rst_n;

    dm_lsu_if #(.AW(AW)) ifc ();

    dm_lsu #(.AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT
    logic [31:0] mem [0:WORDS-1];
    assign ifc.dm_rdata = mem[ifc.dm_addr];
    always @(posedge clk) begin
        if (ifc.dm_wr) mem[ifc.dm_addr] <= ifc.dm_wdata;
    end

    // Reference model state
    logic [31:0] ref_mem [0:WORDS-1];

    typedef struct {
        logic [AW-1:0] waddr;
        logic [31:0]   rdata;
        logic          err;
        logic [31:0]   wword;
        int            nrd;
        int            nwr;
        int            lat;
        int            acc;
        bit            seen;
        int            srd;
        int            swr;
    } exp_t;

    exp_t pend;
    bit   pend_valid = 1'b0;

    int tests = 0;
    int fails = 0;
    int cnt   = 0;

    logic [31:0]   last_wdata;
    logic [AW-1:0] last_waddr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected outcome of the request currently presented on the bus
    task automatic model_accept();
        logic [31:0]   a;
        logic [1:0]    off;
        logic [AW-1:0] w;
        logic [31:0]   old;
        logic [31:0]   sh;
        logic [31:0]   mask;
        int            nbytes;
        bit            st;
        a      = ifc.req_addr;
        off    = a[1:0];
        w      = a[AW+1:2];
        old    = ref_mem[w];
        st     = ifc.req_we;
        nbytes = (ifc.req_size == 2'd0) ? 1 : (ifc.req_size == 2'd1) ? 2 : 4;
        pend.waddr = w;
        pend.rdata = 32'd0;
        pend.wword = 32'd0;
        pend.err   = (ifc.req_size == 2'd3) || ((int'(off) % nbytes) != 0);
        pend.acc   = cnt;
        pend.seen  = 1'b0;
        pend.srd   = 0;
        pend.swr   = 0;
        if (pend.err) begin
            pend.nrd = 0;
            pend.nwr = 0;
            pend.lat = 2;
        end else if (!st) begin
            sh = old >> (8 * int'(off));
            if (nbytes == 1) begin
                pend.rdata = {24'd0, sh[7:0]};
                if (ifc.req_sign && sh[7]) pend.rdata = pend.rdata | 32'hFFFF_FF00;
            end else if (nbytes == 2) begin
                pend.rdata = {16'd0, sh[15:0]};
                if (ifc.req_sign && sh[15]) pend.rdata = pend.rdata | 32'hFFFF_0000;
            end else begin
                pend.rdata = sh;
            end
            pend.nrd = 1;
            pend.nwr = 0;
            pend.lat = 2;
        end else begin
            if (nbytes == 4) mask = 32'hFFFF_FFFF;
            else mask = 32'(((64'd1 << (8 * nbytes)) - 64'd1) << (8 * int'(off)));
            pend.wword = (old & ~mask) | ((ifc.req_wdata << (8 * int'(off))) & mask);
            pend.nrd   = (nbytes < 4) ? 1 : 0;
            pend.nwr   = 1;
            pend.lat   = (nbytes < 4) ? 3 : 2;
        end
        pend_valid = 1'b1;
    endtask

    // A reset discards any outstanding transaction without updating memory
    always @(negedge rst_n) pend_valid = 1'b0;

    // Per-cycle compare process
    always @(negedge clk) begin
        cnt++;
        if (rst_n) begin
            chk("rd_wr_exclusive", {31'd0, ifc.dm_rd & ifc.dm_wr}, 32'd0);
            chk("req_ready", {31'd0, ifc.req_ready}, {31'd0, !pend_valid});
            if (!ifc.dm_wr) chk("dm_wdata_quiet", ifc.dm_wdata, 32'd0);
            if (ifc.dm_rd || ifc.dm_wr) begin
                if (!pend_valid || pend.err) begin
                    chk("dm_unexpected_access", 32'd1, 32'd0);
                end else begin
                    chk("dm_addr", {{(32-AW){1'b0}}, ifc.dm_addr}, {{(32-AW){1'b0}}, pend.waddr});
                    if (ifc.dm_rd) pend.srd++;
                    if (ifc.dm_wr) begin
                        pend.swr++;
                        chk("dm_wdata", ifc.dm_wdata, pend.wword);
                    end
                end
            end
            if (ifc.dm_wr) begin
                last_wdata = ifc.dm_wdata;
                last_waddr = ifc.dm_addr;
            end
            if (ifc.resp_valid) begin
                if (!pend_valid) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    if (!pend.seen) begin
                        chk("latency", 32'(cnt - pend.acc), 32'(pend.lat));
                        pend.seen = 1'b1;
                    end
                    chk("resp_rdata", ifc.resp_rdata, pend.rdata);
                    chk("resp_err", {31'd0, ifc.resp_err}, {31'd0, pend.err});
                    if (ifc.resp_ready) begin
                        chk("n_dm_rd", 32'(pend.srd), 32'(pend.nrd));
                        chk("n_dm_wr", 32'(pend.swr), 32'(pend.nwr));
                        if (pend.nwr > 0) ref_mem[pend.waddr] = pend.wword;
                        pend_valid = 1'b0;
                    end
                end
            end else if (pend_valid && pend.seen) begin
                chk("resp_dropped", 32'd1, 32'd0);
            end
            if (ifc.req_valid && ifc.req_ready) model_accept();
        end
    end

    task automatic check_rst(input string tag);
        chk({tag, "_req_ready"},  {31'd0, ifc.req_ready},  32'd1);
        chk({tag, "_resp_valid"}, {31'd0, ifc.resp_valid}, 32'd0);
        chk({tag, "_resp_err"},   {31'd0, ifc.resp_err},   32'd0);
        chk({tag, "_resp_rdata"}, ifc.resp_rdata,          32'd0);
        chk({tag, "_dm_rd"},      {31'd0, ifc.dm_rd},      32'd0);
        chk({tag, "_dm_wr"},      {31'd0, ifc.dm_wr},      32'd0);
        chk({tag, "_dm_addr"},    {{(32-AW){1'b0}}, ifc.dm_addr}, 32'd0);
        chk({tag, "_dm_wdata"},   ifc.dm_wdata,            32'd0);
    endtask

    // Issue one request and consume its response. Called just after a
    // rising edge; returns just after a rising edge.
    task automatic do_req(input bit we, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int stall, input bit pulse,
                          output logic [31:0] rd, output logic er);
        int n;
        rd = 32'hX;
        er = 1'bX;
        ifc.req_valid = 1'b1;
        ifc.req_we    = we;
        ifc.req_size  = sz;
        ifc.req_sign  = sg;
        ifc.req_addr  = a;
        ifc.req_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.req_ready && n < 20);
        if (!ifc.req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            ifc.req_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        ifc.req_addr  = $urandom;
        ifc.req_wdata = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.resp_valid && n < 20);
        if (!ifc.resp_valid) begin
            chk("resp_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            return;
        end
        rd = ifc.resp_rdata;
        er = ifc.resp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            ifc.req_valid = pulse && (i == 0);
            ifc.req_we    = 1'b0;
            ifc.req_size  = 2'd2;
            ifc.req_addr  = 32'h0;
            @(negedge clk);
            chk("stall_resp_valid", {31'd0, ifc.resp_valid}, 32'd1);
            chk("stall_req_ready",  {31'd0, ifc.req_ready},  32'd0);
            chk("stall_resp_rdata", ifc.resp_rdata, rd);
            chk("stall_resp_err",   {31'd0, ifc.resp_err}, {31'd0, er});
        end
        @(posedge clk); #1;
        ifc.req_valid  = 1'b0;
        ifc.resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        ifc.resp_ready = 1'b0;
        @(negedge clk);
        chk("post_resp_req_ready",  {31'd0, ifc.req_ready},  32'd1);
        chk("post_resp_resp_valid", {31'd0, ifc.resp_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] v;
        int          n;
        bit          we;
        logic [1:0]  sz;
        logic [31:0] a;

        rst_n          = 1'b0;
        ifc.req_valid  = 1'b0;
        ifc.req_we     = 1'b0;
        ifc.req_size   = 2'd0;
        ifc.req_sign   = 1'b0;
        ifc.req_addr   = 32'd0;
        ifc.req_wdata  = 32'd0;
        ifc.resp_ready = 1'b0;
        last_wdata     = 32'd0;
        last_waddr     = '0;
        for (int i = 0; i < WORDS; i++) begin
            v          = $urandom;
            mem[i]     = v;
            ref_mem[i] = v;
        end
        #2;
        check_rst("reset");
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store, word load
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er);
        chk("L_sw_err", {31'd0, er}, 32'd0);
        chk("L_sw_rdata", rd, 32'd0);
        chk("L_sw_wdata", last_wdata, 32'hDEADBEEF);
        chk("L_sw_waddr", {{(32-AW){1'b0}}, last_waddr}, 32'd4);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("L_lw_rdata", rd, 32'hDEADBEEF);
        chk("L_lw_err", {31'd0, er}, 32'd0);

        // Byte store and byte loads
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5, 0, 1'b0, rd, er);
        chk("L_sb_wdata", last_wdata, 32'hDEADA5EF);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, 1'b0, rd, er);
        chk("L_lb_signed", rd, 32'hFFFFFFA5);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, 1'b0, rd, er);
        chk("L_lb_unsigned", rd, 32'h000000A5);

        // Half store and loads
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 0, 1'b0, rd, er);
        chk("L_sh_wdata", last_wdata, 32'h1234A5EF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("L_lw_after_sh", rd, 32'h1234A5EF);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, 1'b0, rd, er);
        chk("L_lh_hi_signed", rd, 32'h00001234);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("L_lh_lo_signed", rd, 32'hFFFFA5EF);

        // Error cases
        do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0, 1'b0, rd, er);
        chk("L_err_lw_err", {31'd0, er}, 32'd1);
        chk("L_err_lw_rdata", rd, 32'd0);
        do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'h5555, 0, 1'b0, rd, er);
        chk("L_err_sh_err", {31'd0, er}, 32'd1);
        chk("L_err_sh_rdata", rd, 32'd0);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("L_err_size3_err", {31'd0, er}, 32'd1);
        chk("L_err_size3_rdata", rd, 32'd0);

        // Response back-pressure with a stray request pulse
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, 1'b1, rd, er);
        chk("L_stall_rdata", rd, 32'h1234A5EF);

        // Reset in the middle of a read-modify-write
        ifc.req_valid = 1'b1;
        ifc.req_we    = 1'b1;
        ifc.req_size  = 2'd0;
        ifc.req_sign  = 1'b0;
        ifc.req_addr  = 32'h10;
        ifc.req_wdata = 32'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.dm_rd && n < 10);
        chk("rmw_rd_seen", {31'd0, ifc.dm_rd}, 32'd1);
        #2;
        rst_n         = 1'b0;
        ifc.req_valid = 1'b0;
        #1;
        check_rst("midreset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
        chk("L_after_reset", rd, 32'h1234A5EF);

        // Address wrap: 0x90 aliases word 4
        do_req(1'b0, 2'd2, 1'b0, 32'h90, 32'h0, 0, 1'b0, rd, er);
        chk("L_wrap", rd, 32'h1234A5EF);

        // Randomized phase, checked by the compare process
        for (int i = 0; i < 250; i++) begin
            we = 1'($urandom);
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(we, sz, 1'($urandom), a, $urandom,
                   int'($urandom_range(0, 2)), 1'($urandom), rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
